// File: rtl/bus_interconnect_pkg.sv
// Shared definitions for the bus interconnect: FSM states, error codes,
// slave indices and default region bases.
package bus_interconnect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_ACTIVE        = 2'd1,
        ST_UNMAPPED_RESP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_UNMAPPED = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    localparam logic [1:0] SLV_MEM   = 2'd0;
    localparam logic [1:0] SLV_UART  = 2'd1;
    localparam logic [1:0] SLV_TIMER = 2'd2;

    localparam int NUM_SLAVES = 3;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'h4000_0000;
    localparam logic [31:0] DEF_S2_BASE = 32'h4001_0000;

    // Slave index to one-hot enable vector; out-of-range index selects nothing.
    function automatic logic [NUM_SLAVES-1:0] idx_to_sel(input logic [1:0] idx);
        logic [NUM_SLAVES-1:0] sel;
        sel = '0;
        case (idx)
            SLV_MEM:   sel = 3'b001;
            SLV_UART:  sel = 3'b010;
            SLV_TIMER: sel = 3'b100;
            default:   sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_interconnect_addr_decoder.sv
// Combinational address decoder: one-hot slave select plus unmapped flag.
// Any address that hits zero regions, or more than one, is reported unmapped.
module bus_addr_decoder
    import bus_interconnect_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DEF_S0_BASE,
    parameter logic [31:0] S1_BASE = DEF_S1_BASE,
    parameter logic [31:0] S2_BASE = DEF_S2_BASE
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [1:0]            idx,
    output logic                  unmapped
);

    logic [NUM_SLAVES-1:0] hit;
    logic                  unused_low_addr;

    assign unused_low_addr = ^addr[15:0];

    // Region compare: memory on the top nibble, peripherals on the upper half-word.
    always_comb begin
        hit    = '0;
        hit[0] = (addr[31:28] == S0_BASE[31:28]);
        hit[1] = (addr[31:16] == S1_BASE[31:16]);
        hit[2] = (addr[31:16] == S2_BASE[31:16]);
    end

    // Exactly-one-hit qualification and index encoding.
    always_comb begin
        unmapped = !$onehot(hit);
        sel      = unmapped ? '0 : hit;
        idx      = SLV_MEM;
        if (sel[1]) idx = SLV_UART;
        if (sel[2]) idx = SLV_TIMER;
    end

endmodule

// File: rtl/bus_interconnect.sv
// Single-master, three-slave bus interconnect with zero-wait forwarding,
// wait-state tracking with timeout, unmapped-address response and a sticky
// first-error status register.
//
// state            | meaning
// -----------------+---------------------------------------------------------
// ST_IDLE          | decode fresh request; complete same cycle if slave ready
// ST_ACTIVE        | waiting on latched slave; counting toward timeout
// ST_UNMAPPED_RESP | one-cycle error response for an unmapped address
module bus_interconnect
    import bus_interconnect_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] S0_BASE        = DEF_S0_BASE,
    parameter logic [31:0] S1_BASE        = DEF_S1_BASE,
    parameter logic [31:0] S2_BASE        = DEF_S2_BASE
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    input  logic        bus_write,
    input  logic        bus_enable,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,

    output logic [31:0] s0_addr,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_write,
    output logic        s0_enable,
    input  logic [31:0] s0_rdata,
    input  logic        s0_ready,

    output logic [31:0] s1_addr,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    output logic        s1_write,
    output logic        s1_enable,
    input  logic [31:0] s1_rdata,
    input  logic        s1_ready,

    output logic [31:0] s2_addr,
    output logic [31:0] s2_wdata,
    output logic [3:0]  s2_wstrb,
    output logic        s2_write,
    output logic        s2_enable,
    input  logic [31:0] s2_rdata,
    input  logic        s2_ready,

    input  logic        err_clear,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [31:0] err_addr
);

    // One extra bit so the counter can hold TIMEOUT_CYCLES itself.
    localparam int            CW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_1  = CW'(1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           txn_addr_q, txn_addr_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic [1:0]            dec_idx;
    logic                  dec_unmapped;

    logic [1:0]            route_idx;
    logic                  route_ready;
    logic [31:0]           route_rdata;

    logic [NUM_SLAVES-1:0] slv_en;
    logic                  err_event;
    logic [1:0]            err_event_code;

    bus_addr_decoder #(
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE),
        .S2_BASE (S2_BASE)
    ) u_decoder (
        .addr     (bus_addr),
        .sel      (dec_sel),
        .idx      (dec_idx),
        .unmapped (dec_unmapped)
    );

    // Request payload is broadcast; only the enable qualifies a slave.
    assign s0_addr  = bus_addr;
    assign s0_wdata = bus_wdata;
    assign s0_wstrb = bus_wstrb;
    assign s0_write = bus_write;
    assign s1_addr  = bus_addr;
    assign s1_wdata = bus_wdata;
    assign s1_wstrb = bus_wstrb;
    assign s1_write = bus_write;
    assign s2_addr  = bus_addr;
    assign s2_wdata = bus_wdata;
    assign s2_wstrb = bus_wstrb;
    assign s2_write = bus_write;

    assign s0_enable = slv_en[0];
    assign s1_enable = slv_en[1];
    assign s2_enable = slv_en[2];

    // Fresh decode in IDLE, latched slave while a transaction is outstanding.
    assign route_idx = (state_q == ST_IDLE) ? dec_idx : idx_q;

    // Response mux: only the routed slave's ready/rdata are ever observed.
    always_comb begin
        route_ready = 1'b0;
        route_rdata = '0;
        case (route_idx)
            SLV_MEM: begin
                route_ready = s0_ready;
                route_rdata = s0_rdata;
            end
            SLV_UART: begin
                route_ready = s1_ready;
                route_rdata = s1_rdata;
            end
            SLV_TIMER: begin
                route_ready = s2_ready;
                route_rdata = s2_rdata;
            end
            default: begin
                route_ready = 1'b0;
                route_rdata = '0;
            end
        endcase
    end

    // State, wait counter, latched slave index and transaction address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= SLV_MEM;
            txn_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            txn_addr_q <= txn_addr_d;
        end
    end

    // Next-state, slave enables, upstream response and error events.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        txn_addr_d     = txn_addr_q;
        slv_en         = '0;
        bus_ready      = 1'b0;
        bus_rdata      = '0;
        err_event      = 1'b0;
        err_event_code = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (bus_enable) begin
                    if (dec_unmapped) begin
                        txn_addr_d = bus_addr;
                        state_d    = ST_UNMAPPED_RESP;
                    end else begin
                        slv_en = dec_sel;
                        if (route_ready) begin
                            bus_ready = 1'b1;
                            bus_rdata = route_rdata;
                        end else begin
                            idx_d      = dec_idx;
                            txn_addr_d = bus_addr;
                            cnt_d      = CNT_1;
                            state_d    = ST_ACTIVE;
                        end
                    end
                end
            end

            ST_ACTIVE: begin
                if (!bus_enable) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (route_ready) begin
                    slv_en    = idx_to_sel(idx_q);
                    bus_ready = 1'b1;
                    bus_rdata = route_rdata;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q >= TO_CNT) begin
                    bus_ready      = 1'b1;
                    err_event      = 1'b1;
                    err_event_code = ERR_TIMEOUT;
                    cnt_d          = '0;
                    state_d        = ST_IDLE;
                end else begin
                    slv_en = idx_to_sel(idx_q);
                    cnt_d  = cnt_q + CNT_1;
                end
            end

            ST_UNMAPPED_RESP: begin
                bus_ready      = bus_enable;
                err_event      = 1'b1;
                err_event_code = ERR_UNMAPPED;
                state_d        = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Nothing reaches the slaves or upstream while reset is held.
        if (!rst_n) begin
            slv_en    = '0;
            bus_ready = 1'b0;
            bus_rdata = '0;
        end
    end

    // Sticky first-error capture; a clear in the same cycle as a new error
    // makes room for that error instead of discarding it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_addr  <= '0;
        end else if (err_event && (!err_valid || err_clear)) begin
            err_valid <= 1'b1;
            err_code  <= err_event_code;
            err_addr  <= txn_addr_q;
        end else if (err_clear) begin
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect with a short timeout of 8 cycles.
module tb_bus_interconnect;

    logic        clk;
    logic        rst_n;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_write, bus_enable, bus_ready;
    logic [31:0] s0_addr, s0_wdata, s0_rdata;
    logic [3:0]  s0_wstrb;
    logic        s0_write, s0_enable, s0_ready;
    logic [31:0] s1_addr, s1_wdata, s1_rdata;
    logic [3:0]  s1_wstrb;
    logic        s1_write, s1_enable, s1_ready;
    logic [31:0] s2_addr, s2_wdata, s2_rdata;
    logic [3:0]  s2_wstrb;
    logic        s2_write, s2_enable, s2_ready;
    logic        err_clear, err_valid;
    logic [1:0]  err_code;
    logic [31:0] err_addr;

    int passed = 0;
    int total  = 0;
    int en_cnt;
    int rdy_cnt;

    bus_interconnect #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_write  (bus_write),
        .bus_enable (bus_enable),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .s0_addr    (s0_addr),
        .s0_wdata   (s0_wdata),
        .s0_wstrb   (s0_wstrb),
        .s0_write   (s0_write),
        .s0_enable  (s0_enable),
        .s0_rdata   (s0_rdata),
        .s0_ready   (s0_ready),
        .s1_addr    (s1_addr),
        .s1_wdata   (s1_wdata),
        .s1_wstrb   (s1_wstrb),
        .s1_write   (s1_write),
        .s1_enable  (s1_enable),
        .s1_rdata   (s1_rdata),
        .s1_ready   (s1_ready),
        .s2_addr    (s2_addr),
        .s2_wdata   (s2_wdata),
        .s2_wstrb   (s2_wstrb),
        .s2_write   (s2_write),
        .s2_enable  (s2_enable),
        .s2_rdata   (s2_rdata),
        .s2_ready   (s2_ready),
        .err_clear  (err_clear),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_addr   (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 2 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic bus_req(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] ws);
        bus_addr   = a;
        bus_write  = wr;
        bus_wdata  = wd;
        bus_wstrb  = ws;
        bus_enable = 1'b1;
    endtask

    task automatic bus_idle();
        bus_enable = 1'b0;
        bus_write  = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_wstrb  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        err_clear = 1'b0;
        bus_idle();
        s0_ready = 1'b0; s0_rdata = '0;
        s1_ready = 1'b0; s1_rdata = '0;
        s2_ready = 1'b0; s2_rdata = '0;

        // Reset values
        next_cycle();
        next_cycle();
        settle();
        chk("rst_bus_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_enables", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        chk("rst_err_valid", {31'd0, err_valid}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        rst_n = 1'b1;

        // Zero-wait read from memory
        next_cycle();
        s0_ready = 1'b1;
        s0_rdata = 32'h1234_5678;
        bus_req(32'h0000_0010, 1'b0, 32'd0, 4'h0);
        settle();
        chk("r0_bus_ready", {31'd0, bus_ready}, 32'd1);
        chk("r0_bus_rdata", bus_rdata, 32'h1234_5678);
        chk("r0_enables", {29'd0, s2_enable, s1_enable, s0_enable}, 32'b001);

        // Released bus: no ready, zero data, even with a slave ready
        next_cycle();
        bus_idle();
        settle();
        chk("idle_bus_ready", {31'd0, bus_ready}, 32'd0);
        chk("idle_bus_rdata", bus_rdata, 32'd0);
        chk("idle_enables", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);

        // UART write, slave ready after 3 waits; s0 stays ready and must be ignored
        next_cycle();
        s0_rdata = 32'hBAD0_BAD0;
        bus_req(32'h4000_0004, 1'b1, 32'h0000_00A5, 4'b0001);
        settle();
        chk("w1_s1_wdata", s1_wdata, 32'h0000_00A5);
        chk("w1_s1_wstrb", {28'd0, s1_wstrb}, 32'h1);
        chk("w1_s1_write", {31'd0, s1_write}, 32'd1);
        en_cnt  = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                next_cycle();
                s1_ready = (i == 3);
                settle();
            end
            if (s1_enable === 1'b1) en_cnt++;
            if (bus_ready === 1'b1) rdy_cnt++;
            chk("w1_other_en", {30'd0, s2_enable, s0_enable}, 32'd0);
        end
        chk("w1_s1_enable_cycles", en_cnt, 32'd4);
        chk("w1_ready_count", rdy_cnt, 32'd1);
        next_cycle();
        bus_idle();
        s1_ready = 1'b0;
        s0_ready = 1'b0;
        settle();
        chk("w1_after_ready", {31'd0, bus_ready}, 32'd0);
        chk("w1_err_valid", {31'd0, err_valid}, 32'd0);
        // Back in IDLE: a ready memory read completes in the same cycle
        next_cycle();
        s0_ready = 1'b1;
        s0_rdata = 32'h0BAD_F00D;
        bus_req(32'h0000_0100, 1'b0, 32'd0, 4'h0);
        settle();
        chk("w1_idle_again", {31'd0, bus_ready}, 32'd1);
        chk("w1_idle_rdata", bus_rdata, 32'h0BAD_F00D);
        next_cycle();
        bus_idle();
        s0_ready = 1'b0;

        // Unmapped read: response in the second cycle, error captured
        bus_req(32'h8000_0000, 1'b0, 32'd0, 4'h0);
        settle();
        chk("um_c1_ready", {31'd0, bus_ready}, 32'd0);
        chk("um_c1_enables", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        next_cycle();
        settle();
        chk("um_c2_ready", {31'd0, bus_ready}, 32'd1);
        chk("um_c2_rdata", bus_rdata, 32'd0);
        next_cycle();
        bus_idle();
        settle();
        chk("um_err_valid", {31'd0, err_valid}, 32'd1);
        chk("um_err_code", {30'd0, err_code}, 32'd1);
        chk("um_err_addr", err_addr, 32'h8000_0000);

        // Clear coinciding with a new unmapped error keeps the new one
        next_cycle();
        bus_req(32'hC000_0000, 1'b0, 32'd0, 4'h0);
        next_cycle();
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        bus_idle();
        settle();
        chk("clr_new_valid", {31'd0, err_valid}, 32'd1);
        chk("clr_new_addr", err_addr, 32'hC000_0000);
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        settle();
        chk("clr_valid", {31'd0, err_valid}, 32'd0);
        chk("clr_code", {30'd0, err_code}, 32'd0);

        // Timer read that never completes: forced response 8 cycles after accept
        s2_rdata = 32'hDEAD_BEEF;
        bus_req(32'h4001_0000, 1'b0, 32'd0, 4'h0);
        settle();
        chk("to_accept_en", {31'd0, s2_enable}, 32'd1);
        chk("to_accept_ready", {31'd0, bus_ready}, 32'd0);
        rdy_cnt = 0;
        en_cnt  = 0;
        for (int k = 1; k < 8; k++) begin
            next_cycle();
            settle();
            if (bus_ready === 1'b1) rdy_cnt++;
            if (s2_enable === 1'b1) en_cnt++;
        end
        chk("to_early_ready", rdy_cnt, 32'd0);
        chk("to_wait_enables", en_cnt, 32'd7);
        next_cycle();
        settle();
        chk("to_c8_ready", {31'd0, bus_ready}, 32'd1);
        chk("to_c8_rdata", bus_rdata, 32'd0);
        chk("to_c8_s2_en", {31'd0, s2_enable}, 32'd0);
        next_cycle();
        bus_idle();
        settle();
        chk("to_err_valid", {31'd0, err_valid}, 32'd1);
        chk("to_err_code", {30'd0, err_code}, 32'd2);
        chk("to_err_addr", err_addr, 32'h4001_0000);

        // Later unmapped error is dropped while the timeout is held
        next_cycle();
        bus_req(32'h9000_0000, 1'b0, 32'd0, 4'h0);
        next_cycle();
        next_cycle();
        bus_idle();
        settle();
        chk("drop_err_code", {30'd0, err_code}, 32'd2);
        chk("drop_err_addr", err_addr, 32'h4001_0000);
        err_clear = 1'b1;
        next_cycle();
        err_clear = 1'b0;
        settle();
        chk("to_clr_valid", {31'd0, err_valid}, 32'd0);

        // Stalled memory read released by upstream, then a UART read
        next_cycle();
        bus_req(32'h0000_0000, 1'b0, 32'd0, 4'h0);
        next_cycle();
        settle();
        chk("rel_stall_en", {31'd0, s0_enable}, 32'd1);
        next_cycle();
        bus_idle();
        settle();
        chk("rel_drop_en", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        chk("rel_drop_ready", {31'd0, bus_ready}, 32'd0);
        next_cycle();
        s1_ready = 1'b1;
        s1_rdata = 32'h0000_55AA;
        bus_req(32'h4000_0000, 1'b0, 32'd0, 4'h0);
        settle();
        chk("rel_s1_routing", {29'd0, s2_enable, s1_enable, s0_enable}, 32'b010);
        chk("rel_s1_ready", {31'd0, bus_ready}, 32'd1);
        chk("rel_s1_rdata", bus_rdata, 32'h0000_55AA);
        chk("rel_no_err", {31'd0, err_valid}, 32'd0);
        next_cycle();
        bus_idle();
        s1_ready = 1'b0;

        // Reset in the middle of an outstanding transaction (error pending first)
        bus_req(32'hA000_0000, 1'b0, 32'd0, 4'h0);
        next_cycle();
        next_cycle();
        bus_idle();
        settle();
        chk("mr_err_pre", {31'd0, err_valid}, 32'd1);
        next_cycle();
        bus_req(32'h4001_0000, 1'b0, 32'd0, 4'h0);
        next_cycle();
        settle();
        chk("mr_active_en", {31'd0, s2_enable}, 32'd1);
        rst_n = 1'b0;
        settle();
        chk("mr_hold_en", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        chk("mr_hold_ready", {31'd0, bus_ready}, 32'd0);
        next_cycle();
        bus_idle();
        settle();
        chk("mr_edge_en", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        chk("mr_edge_ready", {31'd0, bus_ready}, 32'd0);
        chk("mr_edge_err", {31'd0, err_valid}, 32'd0);
        rst_n = 1'b1;
        next_cycle();
        settle();
        chk("mr_post_en", {29'd0, s2_enable, s1_enable, s0_enable}, 32'd0);
        chk("mr_post_ready", {31'd0, bus_ready}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
